// File: rtl/ll_frame_pkg.sv
// ll_frame_pkg: shared types and helpers for the LocalLink frame engine.
//   tx_state_t / rx_state_t : FSM encodings (IDLE, HDR, PAY)
//   HDR_FILL_DEFAULT        : default value of header beats 1..HDR_LEN-1
//   clog2()                 : ceiling log2, usable in parameter expressions
package ll_frame_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_PAY  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HDR  = 2'd1,
    RX_PAY  = 2'd2
  } rx_state_t;

  localparam logic [7:0] HDR_FILL_DEFAULT = 8'hA5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ll_frame_engine_if.sv
// ll_frame_engine_if: bundles every non-clock/reset signal of the frame engine.
//   LocalLink RX : rx_data, rx_sof, rx_eof, rx_src_rdy           (into engine)
//   LocalLink TX : tx_data, tx_sof, tx_eof, tx_src_rdy (out), tx_dest_rdy (in)
//   App TX side  : start_tx, length_tx, data_tx, data_tx_valid (in),
//                  data_tx_ready, busy (out)
//   App RX side  : rx_payload, rx_payload_valid, rx_len,
//                  rx_frame_done, rx_frame_err (out)
// Modports: slave = engine view, master = client/application view.
interface ll_frame_engine_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_sof;
  logic              rx_eof;
  logic              rx_src_rdy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_sof;
  logic              tx_eof;
  logic              tx_src_rdy;
  logic              tx_dest_rdy;
  logic              start_tx;
  logic [LEN_W-1:0]  length_tx;
  logic [DATA_W-1:0] data_tx;
  logic              data_tx_valid;
  logic              data_tx_ready;
  logic              busy;
  logic [DATA_W-1:0] rx_payload;
  logic              rx_payload_valid;
  logic [LEN_W-1:0]  rx_len;
  logic              rx_frame_done;
  logic              rx_frame_err;

  modport slave (
    input  rx_data, rx_sof, rx_eof, rx_src_rdy, tx_dest_rdy,
           start_tx, length_tx, data_tx, data_tx_valid,
    output tx_data, tx_sof, tx_eof, tx_src_rdy, data_tx_ready, busy,
           rx_payload, rx_payload_valid, rx_len, rx_frame_done, rx_frame_err
  );

  modport master (
    output rx_data, rx_sof, rx_eof, rx_src_rdy, tx_dest_rdy,
           start_tx, length_tx, data_tx, data_tx_valid,
    input  tx_data, tx_sof, tx_eof, tx_src_rdy, data_tx_ready, busy,
           rx_payload, rx_payload_valid, rx_len, rx_frame_done, rx_frame_err
  );
endinterface

// File: rtl/ll_sync_fifo.sv
// ll_sync_fifo: first-word-fall-through FIFO for the TX payload.
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data     : write strobe and data (dropped when full)
//   pop                 : consume head (ignored when empty)
//   head                : current head word, valid whenever !empty
//   full, empty         : status derived from the registered occupancy
module ll_sync_fifo
  import ll_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty; pointers wrap freely.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = count[AW];          // only set when count == DEPTH
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/ll_frame_engine.sv
// ll_frame_engine: LocalLink framer/deframer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ll_frame_engine_if.slave (LocalLink RX/TX plus application side)
// TX: start_tx latches a length, emits HDR_LEN header beats (length, then fill)
//     and drains that many payload beats from the FIFO, with full back-pressure.
// RX: strips the header, streams payload, checks the beat count against the
//     header length and pulses done/err one cycle after the closing beat.
module ll_frame_engine
  import ll_frame_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter int         LEN_W      = 8,
  parameter int         HDR_LEN    = 2,
  parameter logic [7:0] HDR_FILL   = HDR_FILL_DEFAULT,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  ll_frame_engine_if.slave bus
);
  localparam int HC_W = clog2(HDR_LEN + 1);

  // ---------------- TX ----------------
  tx_state_t         tx_state_reg;
  logic [LEN_W-1:0]  tx_len_reg;
  logic [LEN_W-1:0]  tx_pay_cnt_reg;
  logic [HC_W-1:0]   tx_hdr_cnt_reg;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_pop;
  logic              tx_src_rdy_c;
  logic              tx_sof_c;
  logic              tx_eof_c;
  logic [DATA_W-1:0] tx_data_c;

  ll_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.data_tx_valid),
    .push_data (bus.data_tx),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Beat outputs decode from registered state and the FIFO head, so a word
  // pushed at edge N can leave at the next cycle and stalled beats hold.
  always_comb begin
    tx_src_rdy_c = 1'b0;
    tx_sof_c     = 1'b0;
    tx_eof_c     = 1'b0;
    tx_data_c    = '0;
    case (tx_state_reg)
      TX_HDR: begin
        tx_src_rdy_c = 1'b1;
        tx_sof_c     = (tx_hdr_cnt_reg == '0);
        tx_data_c    = (tx_hdr_cnt_reg == '0) ? DATA_W'(tx_len_reg) : DATA_W'(HDR_FILL);
      end
      TX_PAY: begin
        tx_src_rdy_c = !fifo_empty;
        tx_data_c    = fifo_head;
        tx_eof_c     = !fifo_empty && (tx_pay_cnt_reg == tx_len_reg - 1'b1);
      end
      default: ;
    endcase
  end

  assign fifo_pop          = (tx_state_reg == TX_PAY) && !fifo_empty && bus.tx_dest_rdy;
  assign bus.tx_src_rdy    = tx_src_rdy_c;
  assign bus.tx_sof        = tx_sof_c;
  assign bus.tx_eof        = tx_eof_c;
  assign bus.tx_data       = tx_data_c;
  assign bus.busy          = (tx_state_reg != TX_IDLE);
  assign bus.data_tx_ready = !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg   <= TX_IDLE;
      tx_len_reg     <= '0;
      tx_pay_cnt_reg <= '0;
      tx_hdr_cnt_reg <= '0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (bus.start_tx && bus.length_tx != '0) begin
            tx_len_reg     <= bus.length_tx;
            tx_pay_cnt_reg <= '0;
            tx_hdr_cnt_reg <= '0;
            tx_state_reg   <= TX_HDR;
          end
        end
        TX_HDR: begin
          if (bus.tx_dest_rdy) begin
            if (tx_hdr_cnt_reg == HC_W'(HDR_LEN - 1)) tx_state_reg <= TX_PAY;
            else tx_hdr_cnt_reg <= tx_hdr_cnt_reg + 1'b1;
          end
        end
        TX_PAY: begin
          if (fifo_pop) begin
            if (tx_pay_cnt_reg == tx_len_reg - 1'b1) tx_state_reg <= TX_IDLE;
            else tx_pay_cnt_reg <= tx_pay_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_t         rx_state_reg;
  logic [LEN_W-1:0]  rx_exp_reg;
  logic [LEN_W:0]    rx_cnt_reg;
  logic [LEN_W:0]    rx_cnt_next;
  logic [HC_W-1:0]   rx_hdr_cnt_reg;
  logic [DATA_W-1:0] rx_payload_reg;
  logic              rx_payload_valid_reg;
  logic [LEN_W-1:0]  rx_len_reg;
  logic              rx_done_reg;
  logic              rx_err_reg;
  logic [LEN_W-1:0]  sof_len;

  assign sof_len     = bus.rx_data[LEN_W-1:0];
  // Saturating so an overlong frame can never wrap back into a match.
  assign rx_cnt_next = (&rx_cnt_reg) ? rx_cnt_reg : rx_cnt_reg + 1'b1;

  assign bus.rx_payload       = rx_payload_reg;
  assign bus.rx_payload_valid = rx_payload_valid_reg;
  assign bus.rx_len           = rx_len_reg;
  assign bus.rx_frame_done    = rx_done_reg;
  assign bus.rx_frame_err     = rx_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg         <= RX_IDLE;
      rx_exp_reg           <= '0;
      rx_cnt_reg           <= '0;
      rx_hdr_cnt_reg       <= '0;
      rx_payload_reg       <= '0;
      rx_payload_valid_reg <= 1'b0;
      rx_len_reg           <= '0;
      rx_done_reg          <= 1'b0;
      rx_err_reg           <= 1'b0;
    end else begin
      rx_payload_valid_reg <= 1'b0;
      rx_done_reg          <= 1'b0;
      rx_err_reg           <= 1'b0;
      if (bus.rx_src_rdy) begin
        if (bus.rx_sof) begin
          // A sof outside IDLE aborts the frame in flight; the beat always
          // starts a new frame.
          if (rx_state_reg != RX_IDLE) rx_err_reg <= 1'b1;
          rx_exp_reg     <= sof_len;
          rx_cnt_reg     <= '0;
          rx_hdr_cnt_reg <= HC_W'(1);
          if (bus.rx_eof) begin
            if (HDR_LEN == 1 && sof_len == '0) begin
              rx_done_reg <= 1'b1;
              rx_len_reg  <= sof_len;
            end else begin
              rx_err_reg <= 1'b1;
            end
            rx_state_reg <= RX_IDLE;
          end else begin
            rx_state_reg <= (HDR_LEN == 1) ? RX_PAY : RX_HDR;
          end
        end else begin
          case (rx_state_reg)
            RX_HDR: begin
              if (bus.rx_eof) begin
                rx_err_reg   <= 1'b1;
                rx_state_reg <= RX_IDLE;
              end else if (rx_hdr_cnt_reg == HC_W'(HDR_LEN - 1)) begin
                rx_state_reg <= RX_PAY;
              end else begin
                rx_hdr_cnt_reg <= rx_hdr_cnt_reg + 1'b1;
              end
            end
            RX_PAY: begin
              rx_payload_reg       <= bus.rx_data;
              rx_payload_valid_reg <= 1'b1;
              rx_cnt_reg           <= rx_cnt_next;
              if (bus.rx_eof) begin
                if (rx_cnt_next == {1'b0, rx_exp_reg}) begin
                  rx_done_reg <= 1'b1;
                  rx_len_reg  <= rx_exp_reg;
                end else begin
                  rx_err_reg <= 1'b1;
                end
                rx_state_reg <= RX_IDLE;
              end
            end
            default: ;  // IDLE: beats without sof are discarded
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ll_frame_engine.sv
// tb_ll_frame_engine: directed bench for ll_frame_engine (default parameters).
module tb_ll_frame_engine;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ll_frame_engine_if #(.DATA_W(8), .LEN_W(8)) bus ();

  ll_frame_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [30:0] all_out;
  assign all_out = {bus.tx_data, bus.tx_sof, bus.tx_eof, bus.tx_src_rdy, bus.busy,
                    bus.rx_payload, bus.rx_payload_valid, bus.rx_len,
                    bus.rx_frame_done, bus.rx_frame_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tx_expect(input string tag, input logic [7:0] d, input logic s, input logic e);
    check(tag, 32'({bus.tx_src_rdy, bus.tx_sof, bus.tx_eof, bus.tx_data}),
               32'({1'b1, s, e, d}));
  endtask

  task automatic push_beat(input logic [7:0] d);
    bus.data_tx       = d;
    bus.data_tx_valid = 1'b1;
    tick();
    bus.data_tx_valid = 1'b0;
  endtask

  task automatic rx_beat(input logic [7:0] d, input logic s, input logic e);
    bus.rx_data    = d;
    bus.rx_sof     = s;
    bus.rx_eof     = e;
    bus.rx_src_rdy = 1'b1;
    tick();
    bus.rx_src_rdy = 1'b0;
    bus.rx_sof     = 1'b0;
    bus.rx_eof     = 1'b0;
  endtask

  // Expected beat k of the 12-beat test frame: 0C, A5, E0..EB.
  function automatic logic [7:0] f1(input int k);
    if (k == 0) return 8'h0C;
    if (k == 1) return 8'hA5;
    return 8'(8'hE0 + k - 2);
  endfunction

  initial begin
    int k;
    int npush;
    checks = 0;
    errors = 0;
    bus.rx_data = '0; bus.rx_sof = 0; bus.rx_eof = 0; bus.rx_src_rdy = 0;
    bus.tx_dest_rdy = 0; bus.start_tx = 0; bus.length_tx = '0;
    bus.data_tx = '0; bus.data_tx_valid = 0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_ready", 32'(bus.data_tx_ready), 32'd1);
    reset = 1'b0;
    tick();

    // 1: prefilled frame, no back-pressure, 14 contiguous beats
    for (int i = 0; i < 12; i++) push_beat(8'(8'hE0 + i));
    bus.tx_dest_rdy = 1'b1;
    bus.start_tx = 1'b1; bus.length_tx = 8'd12;
    tick();
    bus.start_tx = 1'b0;
    check("t1_busy_up", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 14; i++) begin
      tx_expect("t1_beat", f1(i), i == 0, i == 13);
      tick();
    end
    check("t1_busy_down", 32'({bus.busy, bus.tx_src_rdy}), 32'd0);

    // 2: same frame with tx_dest_rdy toggling; stalled beats must hold
    for (int i = 0; i < 12; i++) push_beat(8'(8'hE0 + i));
    bus.tx_dest_rdy = 1'b0;
    bus.start_tx = 1'b1; bus.length_tx = 8'd12;
    tick();
    bus.start_tx = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 14; cyc++) begin
      bus.tx_dest_rdy = (cyc % 2 == 1);
      tx_expect("t2_beat", f1(k), k == 0, k == 13);
      if (bus.tx_dest_rdy) k++;
      tick();
    end
    bus.tx_dest_rdy = 1'b1;
    check("t2_beats_sent", 32'(k), 32'd14);
    check("t2_busy_down", 32'(bus.busy), 32'd0);

    // 3: empty FIFO, data arrives late; second start_tx ignored
    bus.start_tx = 1'b1; bus.length_tx = 8'd4;
    tick();
    bus.start_tx = 1'b0;
    tx_expect("t3_hdr0", 8'h04, 1'b1, 1'b0);
    tick();
    tx_expect("t3_hdr1", 8'hA5, 1'b0, 1'b0);
    bus.start_tx = 1'b1; bus.length_tx = 8'd7;
    tick();
    bus.start_tx = 1'b0;
    check("t3_wait_a", 32'({bus.busy, bus.tx_src_rdy}), 32'd2);
    tick();
    check("t3_wait_b", 32'({bus.busy, bus.tx_src_rdy}), 32'd2);
    k = 0; npush = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      if (npush < 4) begin
        bus.data_tx = 8'(8'h31 + npush);
        bus.data_tx_valid = 1'b1;
        npush++;
      end else begin
        bus.data_tx_valid = 1'b0;
      end
      if (bus.tx_src_rdy) begin
        tx_expect("t3_pay", 8'(8'h31 + k), 1'b0, k == 3);
        k++;
      end
      tick();
    end
    bus.data_tx_valid = 1'b0;
    check("t3_pay_count", 32'(k), 32'd4);
    check("t3_busy_down", 32'(bus.busy), 32'd0);
    tick();
    check("t3_no_restart", 32'(bus.busy), 32'd0);

    // 4: good RX frame 03 A5 11 22 33
    rx_beat(8'h03, 1'b1, 1'b0);
    check("t4_hdr_quiet", 32'({bus.rx_payload_valid, bus.rx_frame_done, bus.rx_frame_err}), 32'd0);
    rx_beat(8'hA5, 1'b0, 1'b0);
    check("t4_hdr_quiet2", 32'(bus.rx_payload_valid), 32'd0);
    rx_beat(8'h11, 1'b0, 1'b0);
    check("t4_pay0", 32'({bus.rx_payload_valid, bus.rx_payload}), 32'h111);
    rx_beat(8'h22, 1'b0, 1'b0);
    check("t4_pay1", 32'({bus.rx_payload_valid, bus.rx_payload, bus.rx_frame_done}), 32'h244);
    rx_beat(8'h33, 1'b0, 1'b1);
    check("t4_last", 32'({bus.rx_payload_valid, bus.rx_payload, bus.rx_frame_done, bus.rx_frame_err}), 32'h4CE);
    check("t4_rx_len", 32'(bus.rx_len), 32'd3);
    tick();
    check("t4_pulse_end", 32'({bus.rx_payload_valid, bus.rx_frame_done}), 32'd0);

    // 5: short frame (len 5, 2 payload beats), then sof mid-payload
    rx_beat(8'h05, 1'b1, 1'b0);
    rx_beat(8'hA5, 1'b0, 1'b0);
    rx_beat(8'h11, 1'b0, 1'b0);
    rx_beat(8'h22, 1'b0, 1'b1);
    check("t5_short_err", 32'({bus.rx_frame_done, bus.rx_frame_err}), 32'd1);
    tick();
    check("t5_err_pulse", 32'(bus.rx_frame_err), 32'd0);
    rx_beat(8'h04, 1'b1, 1'b0);
    rx_beat(8'hA5, 1'b0, 1'b0);
    rx_beat(8'h11, 1'b0, 1'b0);
    check("t5_mid_pay", 32'({bus.rx_payload_valid, bus.rx_payload, bus.rx_frame_err}), 32'h222);
    rx_beat(8'h02, 1'b1, 1'b0);
    check("t5_abort_err", 32'({bus.rx_payload_valid, bus.rx_frame_done, bus.rx_frame_err}), 32'd1);
    rx_beat(8'hA5, 1'b0, 1'b0);
    check("t5_new_hdr", 32'({bus.rx_payload_valid, bus.rx_frame_err}), 32'd0);
    rx_beat(8'h66, 1'b0, 1'b0);
    check("t5_new_pay0", 32'({bus.rx_payload_valid, bus.rx_payload}), 32'h166);
    rx_beat(8'h77, 1'b0, 1'b1);
    check("t5_new_done", 32'({bus.rx_payload_valid, bus.rx_payload, bus.rx_frame_done, bus.rx_frame_err}), 32'h5DE);
    check("t5_rx_len", 32'(bus.rx_len), 32'd2);

    // 6: overfill the FIFO, drain it, then reset in the middle of PAY
    for (int i = 0; i < 16; i++) begin
      check("t6_ready_before", 32'(bus.data_tx_ready), 32'd1);
      push_beat(8'(8'h40 + i));
    end
    check("t6_full", 32'(bus.data_tx_ready), 32'd0);
    push_beat(8'h99);
    check("t6_still_full", 32'(bus.data_tx_ready), 32'd0);
    bus.start_tx = 1'b1; bus.length_tx = 8'd16;
    tick();
    bus.start_tx = 1'b0;
    tx_expect("t6_hdr0", 8'h10, 1'b1, 1'b0);
    tick();
    tx_expect("t6_hdr1", 8'hA5, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      tx_expect("t6_pay", 8'(8'h40 + i), 1'b0, i == 15);
      tick();
    end
    check("t6_drained", 32'({bus.busy, bus.data_tx_ready}), 32'd1);
    bus.start_tx = 1'b1; bus.length_tx = 8'd1;
    tick();
    bus.start_tx = 1'b0;
    tick();
    tick();
    check("t6_dropped_17th", 32'({bus.busy, bus.tx_src_rdy}), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_async_reset", 32'(all_out), 32'd0);
    check("t6_reset_ready", 32'(bus.data_tx_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("t6_after_reset", 32'({bus.busy, bus.tx_src_rdy, bus.tx_eof}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
